// File: rtl/rsa_mmm_if.sv
// Command/result bus between the RSA control FSM (master) and the
// modular-exponentiation datapath (slave).
interface rsa_mmm_if #(
    parameter int WIDTH = 8
);
    // Commands are level-sampled on every enabled rising edge. There is no
    // back-pressure: the datapath takes each command in the cycle it is
    // presented, and done stays high until a clear_mmm pulse without eoc.
    logic             ena;
    logic             clear_mmm;
    logic             ld_a;
    logic             ld_r;
    logic             lock1;
    logic             lock2;
    logic [1:0]       sel1;
    logic             sel2;
    logic             eoc;
    logic [WIDTH-1:0] M;
    logic [WIDTH-1:0] N;
    logic [WIDTH-1:0] R2;
    logic [WIDTH-1:0] C;
    logic             done;

    modport master (
        output ena, clear_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2, eoc, M, N, R2,
        input  C, done
    );

    modport slave (
        input  ena, clear_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2, eoc, M, N, R2,
        output C, done
    );
endinterface

// File: rtl/rsa_mmm_datapath.sv
// RSA datapath: two lockstep bit-serial Montgomery multipliers (unit 0 = X,
// unit 1 = S) plus the x_r / m_r working registers and the result register C.
module rsa_mmm_datapath #(
    parameter int WIDTH = 8
) (
    input logic     clk,
    input logic     rstb,
    rsa_mmm_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = WIDTH + 2;

    logic [SW-1:0]    s_acc [2];
    logic [SW-1:0]    s_nx  [2];
    logic [WIDTH-1:0] a_reg [2];
    logic [WIDTH-1:0] b_reg [2];
    logic [WIDTH-1:0] op_a  [2];
    logic [WIDTH-1:0] op_b  [2];
    logic [WIDTH-1:0] add_b [2];
    logic [WIDTH-1:0] add_n [2];
    logic             q     [2];
    logic [CW-1:0]    cnt   [2];
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] m_r;
    logic [WIDTH-1:0] c_r;
    logic             done_r;

    // S < 2N after a full multiply, so a single conditional subtract reduces it.
    function automatic logic [WIDTH-1:0] reduce(input logic [SW-1:0] s,
                                                input logic [WIDTH-1:0] n);
        return (s >= {2'b00, n}) ? WIDTH'(s - {2'b00, n}) : s[WIDTH-1:0];
    endfunction

    always_comb begin
        op_a[0] = '0;
        op_b[0] = '0;
        unique case (bus.sel1)
            2'b00: begin op_a[0] = bus.R2; op_b[0] = WIDTH'(1); end
            2'b01: begin op_a[0] = x_r;    op_b[0] = m_r;       end
            2'b10: begin op_a[0] = x_r;    op_b[0] = WIDTH'(1); end
            default: begin op_a[0] = '0;   op_b[0] = '0;        end
        endcase
        op_a[1] = bus.sel2 ? m_r : bus.M;
        op_b[1] = bus.sel2 ? m_r : bus.R2;
    end

    always_comb begin
        for (int u = 0; u < 2; u++) begin
            add_b[u] = a_reg[u][0] ? b_reg[u] : '0;
            q[u]     = s_acc[u][0] ^ (a_reg[u][0] & b_reg[u][0]);
            add_n[u] = q[u] ? bus.N : '0;
            s_nx[u]  = SW'(({1'b0, s_acc[u]} + {3'b000, add_b[u]} + {3'b000, add_n[u]}) >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            for (int u = 0; u < 2; u++) begin
                s_acc[u] <= '0;
                a_reg[u] <= '0;
                b_reg[u] <= '0;
                cnt[u]   <= '0;
            end
            x_r    <= '0;
            m_r    <= '0;
            c_r    <= '0;
            done_r <= 1'b0;
        end else if (bus.ena) begin
            for (int u = 0; u < 2; u++) begin
                if (!bus.clear_mmm) begin
                    s_acc[u] <= '0;
                    a_reg[u] <= '0;
                    b_reg[u] <= '0;
                    cnt[u]   <= '0;
                end else if (bus.ld_a) begin
                    s_acc[u] <= '0;
                    a_reg[u] <= op_a[u];
                    b_reg[u] <= op_b[u];
                    cnt[u]   <= '0;
                end else if (!bus.ld_r && (cnt[u] < CW'(WIDTH))) begin
                    s_acc[u] <= s_nx[u];
                    a_reg[u] <= a_reg[u] >> 1;
                    cnt[u]   <= cnt[u] + CW'(1);
                end
            end
            // Capture happens only when neither clear nor a new load is pending.
            if (bus.clear_mmm && !bus.ld_a && bus.ld_r) begin
                if (bus.lock1) x_r <= reduce(s_acc[0], bus.N);
                if (bus.lock2) m_r <= reduce(s_acc[1], bus.N);
            end
            if (bus.eoc) begin
                c_r    <= x_r;
                done_r <= 1'b1;
            end else if (!bus.clear_mmm) begin
                done_r <= 1'b0;
            end
        end
    end

    assign bus.C    = c_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_rsa_mmm_datapath.sv
// Bench for rsa_mmm_datapath: controller-style exponentiation runs checked
// against plain modular arithmetic (modpow, modular inverse of R).
module tb_rsa_mmm_datapath;
    localparam int WIDTH = 8;
    localparam int RADIX = 1 << WIDTH;

    logic clk = 1'b0;
    logic rstb;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [WIDTH-1:0] exp_q[$];

    rsa_mmm_if #(.WIDTH(WIDTH)) bus();
    rsa_mmm_datapath #(.WIDTH(WIDTH)) dut (.clk(clk), .rstb(rstb), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic int modpow(int b, int e, int n);
        int r = 1 % n;
        for (int k = 0; k < e; k++) r = (r * b) % n;
        return r;
    endfunction

    function automatic int r_mod(int n);
        return RADIX % n;
    endfunction

    function automatic int r2_of(int n);
        return (RADIX * RADIX) % n;
    endfunction

    function automatic int rinv(int n);
        for (int r = 0; r < n; r++) if (((r * RADIX) % n) == 1) return r;
        return 0;
    endfunction

    function automatic int mont(int a, int b, int n);
        return (((a * b) % n) * rinv(n)) % n;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_idle();
        bus.ena = 1'b1; bus.clear_mmm = 1'b1; bus.ld_a = 1'b0; bus.ld_r = 1'b0;
        bus.lock1 = 1'b0; bus.lock2 = 1'b0; bus.sel1 = 2'b00; bus.sel2 = 1'b0;
        bus.eoc = 1'b0;
    endtask

    task automatic set_operands(input int m, input int n);
        bus.M  = WIDTH'(m);
        bus.N  = WIDTH'(n);
        bus.R2 = WIDTH'(r2_of(n));
    endtask

    task automatic clear_units();
        bus.clear_mmm = 1'b0; tick(); bus.clear_mmm = 1'b1;
    endtask

    // One multiply: ld_a, WIDTH (+extra) iteration cycles, ld_r.
    task automatic mul(input logic [1:0] s1, input logic s2, input logic l1, input logic l2,
                       input int extra, input bit gap);
        logic [WIDTH+1:0] snap_s;
        logic [3:0]       snap_c;
        bus.sel1 = s1; bus.sel2 = s2; bus.ld_a = 1'b1; tick(); bus.ld_a = 1'b0;
        for (int i = 0; i < WIDTH + extra; i++) begin
            if (gap && i == 3) begin
                snap_s = dut.s_acc[0];
                snap_c = dut.cnt[0];
                bus.ena = 1'b0;
                repeat (4) tick();
                n_tests++;
                if (dut.s_acc[0] !== snap_s || dut.cnt[0] !== snap_c) begin
                    n_fail++;
                    $display("FAIL ena_freeze: s_acc=%0d cnt=%0d, required s_acc=%0d cnt=%0d",
                             dut.s_acc[0], dut.cnt[0], snap_s, snap_c);
                end
                bus.ena = 1'b1;
            end
            tick();
        end
        bus.lock1 = l1; bus.lock2 = l2; bus.ld_r = 1'b1; tick();
        bus.ld_r = 1'b0; bus.lock1 = 1'b0; bus.lock2 = 1'b0;
    endtask

    task automatic run_exp(input int m, input int n, input int e,
                           input int gap_round, input int abort_round);
        logic [WIDTH-1:0] exp_c;
        set_operands(m, n);
        exp_q.push_back(WIDTH'(modpow(m, e, n)));
        clear_units();
        n_tests++;
        if (bus.done !== 1'b0) begin
            n_fail++; $display("FAIL done_clear: done=%0b required 0", bus.done);
        end
        mul(2'b00, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        n_tests++;
        if (dut.x_r !== WIDTH'(r_mod(n))) begin
            n_fail++; $display("FAIL map_x: x_r=%0d required %0d", dut.x_r, r_mod(n));
        end
        n_tests++;
        if (dut.m_r !== WIDTH'((m * RADIX) % n)) begin
            n_fail++; $display("FAIL map_m: m_r=%0d required %0d", dut.m_r, (m * RADIX) % n);
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (i == abort_round) begin
                bus.sel1 = 2'b01; bus.sel2 = 1'b1; bus.ld_a = 1'b1; tick(); bus.ld_a = 1'b0;
                tick(); tick();
                rstb = 1'b0; bus.ena = 1'b0; tick(); rstb = 1'b1; bus.ena = 1'b1;
                n_tests++;
                if (bus.C !== '0 || bus.done !== 1'b0) begin
                    n_fail++; $display("FAIL abort_out: C=%0d done=%0b required 0/0", bus.C, bus.done);
                end
                n_tests++;
                if (dut.x_r !== '0 || dut.m_r !== '0) begin
                    n_fail++; $display("FAIL abort_regs: x_r=%0d m_r=%0d required 0/0", dut.x_r, dut.m_r);
                end
                void'(exp_q.pop_back());
                return;
            end
            mul(2'b01, 1'b1, logic'((e >> i) & 1), 1'b1, 0, (i == gap_round));
        end
        mul(2'b10, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        n_tests++;
        if (bus.done !== 1'b0) begin
            n_fail++; $display("FAIL done_early: done=%0b required 0", bus.done);
        end
        bus.eoc = 1'b1; tick(); bus.eoc = 1'b0;
        exp_c = exp_q.pop_front();
        n_tests++;
        if (bus.C !== exp_c) begin
            n_fail++; $display("FAIL result: M=%0d N=%0d E=%0d C=%0d required %0d", m, n, e, bus.C, exp_c);
        end
        n_tests++;
        if (bus.done !== 1'b1) begin
            n_fail++; $display("FAIL done_set: done=%0b required 1", bus.done);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rstb = 1'b0;
        repeat (2) tick();
        n_tests++;
        if (bus.C !== '0 || bus.done !== 1'b0 || dut.x_r !== '0 || dut.m_r !== '0) begin
            n_fail++;
            $display("FAIL reset: C=%0d done=%0b x_r=%0d m_r=%0d required all 0",
                     bus.C, bus.done, dut.x_r, dut.m_r);
        end
        rstb = 1'b1;
    endtask

    task automatic test_known();
        run_exp(7, 13, 5, -1, -1);
        run_exp(7, 13, 0, -1, -1);
        run_exp(7, 13, 1, -1, -1);
        run_exp(0, 13, 3, -1, -1);
        run_exp(254, 255, 2, -1, -1);
    endtask

    task automatic test_saturation();
        int r9, m11;
        r9  = r_mod(13);
        m11 = (7 * RADIX) % 13;
        set_operands(7, 13);
        clear_units();
        mul(2'b00, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        mul(2'b01, 1'b1, 1'b1, 1'b0, 3, 1'b0);
        n_tests++;
        if (dut.x_r !== WIDTH'(mont(r9, m11, 13)) || dut.m_r !== WIDTH'(m11)) begin
            n_fail++;
            $display("FAIL sat_lock1: x_r=%0d m_r=%0d required %0d/%0d",
                     dut.x_r, dut.m_r, mont(r9, m11, 13), m11);
        end
        mul(2'b00, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        mul(2'b01, 1'b1, 1'b0, 1'b0, 3, 1'b0);
        n_tests++;
        if (dut.x_r !== WIDTH'(r9) || dut.m_r !== WIDTH'(m11)) begin
            n_fail++;
            $display("FAIL sat_nolock: x_r=%0d m_r=%0d required %0d/%0d", dut.x_r, dut.m_r, r9, m11);
        end
        // ld_a and ld_r together: load wins, nothing captured.
        bus.sel1 = 2'b11; bus.ld_a = 1'b1; bus.ld_r = 1'b1; bus.lock1 = 1'b1; bus.lock2 = 1'b1;
        tick();
        bus.ld_a = 1'b0; bus.ld_r = 1'b0; bus.lock1 = 1'b0; bus.lock2 = 1'b0;
        n_tests++;
        if (dut.x_r !== WIDTH'(r9) || dut.m_r !== WIDTH'(m11)) begin
            n_fail++;
            $display("FAIL lda_wins: x_r=%0d m_r=%0d required %0d/%0d", dut.x_r, dut.m_r, r9, m11);
        end
        repeat (WIDTH) tick();
        bus.ld_r = 1'b1; bus.lock1 = 1'b1; tick(); bus.ld_r = 1'b0; bus.lock1 = 1'b0;
        n_tests++;
        if (dut.x_r !== '0) begin
            n_fail++; $display("FAIL zero_operands: x_r=%0d required 0", dut.x_r);
        end
    endtask

    task automatic test_ena_gap();
        run_exp(7, 13, 5, 2, -1);
    endtask

    task automatic test_reset_mid();
        run_exp(7, 13, 5, -1, 3);
        run_exp(7, 13, 5, -1, -1);
        bus.clear_mmm = 1'b0; tick(); bus.clear_mmm = 1'b1;
        n_tests++;
        if (bus.done !== 1'b0 || bus.C !== WIDTH'(modpow(7, 5, 13))) begin
            n_fail++;
            $display("FAIL clear_after_eoc: done=%0b C=%0d required 0/%0d", bus.done, bus.C, modpow(7, 5, 13));
        end
    endtask

    task automatic test_random();
        int n, m, e;
        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(1, 127) * 2 + 1;
            m = $urandom_range(0, n - 1);
            e = $urandom_range(0, 255);
            run_exp(m, n, e, -1, -1);
        end
    endtask

    initial begin
        set_idle();
        set_operands(0, 13);
        test_reset();
        test_known();
        test_saturation();
        test_ena_gap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
